fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

UART transmitter that drains the synchronous FIFO one word at a time and serialises each word onto a single TX line.
- Sits directly downstream of the FIFO: drives its read strobe and consumes its registered read data.
- Handles the FIFO's one-cycle read latency internally.
- Frame format: start bit, WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits.

## Interface
- WIDTH, 8: data bits per frame; matches FIFO WIDTH.
- CLKS_PER_BIT, 16: i_clk cycles per serial bit; legal range ≥ 2.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_tx_en  in  1  permits starting a new frame; a frame in progress always completes.
- i_empty  in  1  FIFO empty flag (FIFO o_empty).
- i_data  in  WIDTH  FIFO read data (FIFO o_data); valid the cycle after o_re.
- o_re  out  1  FIFO read strobe (to FIFO i_re); registered; one-cycle pulse per frame.
- o_tx  out  1  serial line; idle/mark = 1.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse in the final cycle of the last stop bit.
- o_frame_cnt  out  16  frames completed; increments with o_done; wraps 0xFFFF→0x0000.

## Operation
- State machine: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. If i_tx_en && !i_empty, go to POP.
- POP: one cycle with o_re=1. The FIFO samples the read at the edge ending POP.
- LOAD: one cycle, o_re=0. Capture i_data into the WIDTH-bit shift register at the edge ending LOAD; go to START.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA: shift register bit 0 on o_tx. Shift right every CLKS_PER_BIT cycles. Stay for WIDTH bit periods, counted by a bit index of width $clog2(WIDTH)+1.
- PARITY: present only per Configuration. One bit period.
- STOP: o_tx=1 for STOP_BITS bit periods. o_done=1 and o_frame_cnt increments in the last cycle.
  - Exit to POP if i_tx_en && !i_empty in that last cycle, otherwise to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits. Cleared on entry to START and at each bit boundary. A bit ends when the counter equals CLKS_PER_BIT-1.
- i_empty and i_tx_en are sampled only in IDLE and in the last STOP cycle. Changes at other times have no effect.
- i_data is sampled only in LOAD.
- The FIFO never underflows from this block: o_re is only raised after !i_empty is observed.
- Reset, including mid-frame: state=IDLE, o_tx=1, o_re=0, o_busy=0, o_done=0, o_frame_cnt=0, shift register=0, counters=0, all immediately. The partial frame is abandoned. A word already popped is lost.

## Timing
- Cycle 0: IDLE with i_tx_en=1, i_empty=0.
- Cycle 1: o_re=1.
- Cycle 2: LOAD.
- Cycle 3: o_tx falls (start bit).
- Frame length from start edge: (1+WIDTH+P+STOP_BITS)·CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
- Back-to-back frames: exactly 2 mark cycles (POP, LOAD) between the end of one stop bit and the next start bit.
- o_busy rises in the POP cycle and falls in the first IDLE cycle.
- All outputs are registered.

## Configuration
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is included between DATA and STOP.
  - Transmits even parity: the XOR of the WIDTH data bits captured in LOAD.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - No parity logic is synthesised.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles with i_empty=0 → o_tx=1, o_re=0, o_busy=0, o_done=0, o_frame_cnt=0; no o_re until 1 cycle after release.
- Single frame (CLKS_PER_BIT=4, STOP_BITS=1, no parity): FIFO holds 0xA5 → o_re high in cycle 1 only.
  - o_tx: 0 in cycles 3–6, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 in cycles 39–42.
  - o_done in cycle 42; o_frame_cnt=1.
- Parity build: FIFO holds 0x07 → parity bit 1 in cycles 39–42, stop in cycles 43–46, o_done in cycle 46. With 0xA5 the parity bit is 0.
- Back-to-back: FIFO holds 0x00, 0xFF, i_tx_en=1 → exactly 2 mark cycles between frames; second frame's data bits all 1; o_frame_cnt=2; exactly 2 o_re pulses.
- Enable gating: FIFO non-empty, i_tx_en=0 for 50 cycles → no o_re, o_tx=1. Drop i_tx_en mid-frame → the frame completes and no further pop occurs.
- Mid-frame reset: assert i_rst_n=0 during data bit 3 → o_tx=1 in the same cycle. After release with FIFO still non-empty, a new frame starts at cycle 3 after the first IDLE cycle; o_frame_cnt counts from 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word at a time from an upstream synchronous FIFO and serialises it.
// Optional even parity bit is compiled in with `define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tx_en,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_re,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shift_nxt;
  logic               start_ok;
  logic               bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               parity;
`endif

  always_comb begin
    start_ok  = i_tx_en && !i_empty;
    bit_end   = (baud_cnt == BAUD_LAST);
    shift_nxt = shreg >> 1;
  end

  // Outputs are registered alongside the state, so each one is set on the transition into the cycle it describes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
      o_re        <= 1'b0;
      o_tx        <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_re   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (start_ok) begin
            state  <= POP;
            o_re   <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg    <= i_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity   <= ^i_data;
`endif
          baud_cnt <= '0;
          bit_idx  <= '0;
          o_tx     <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            o_tx     <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shift_nxt;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              o_tx    <= parity;
              state   <= PARITY;
`else
              o_tx    <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_tx    <= shift_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          o_tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (start_ok) begin
                state <= POP;
                o_re  <= 1'b1;
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Raise done one edge early so it lands in the final stop cycle.
            if (bit_idx == STOP_LAST && baud_cnt == BAUD_PRE) begin
              o_done      <= 1'b1;
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx with a queue-based FIFO model and a frame-level line model.
module tb_fifo_uart_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CPB   = 4;
  localparam int unsigned STOPB = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS = 1 + WIDTH + P + STOPB;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tx_en;
  logic             empty;
  logic [WIDTH-1:0] data;
  logic             re;
  logic             tx;
  logic             busy;
  logic             done;
  logic [15:0]      frame_cnt;

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [15:0]      exp_cnt  = 16'd0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] pend_word;
  logic             pend = 1'b0;

  fifo_uart_tx #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(STOPB)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_tx_en(tx_en),
    .i_empty(empty),
    .i_data(data),
    .o_re(re),
    .o_tx(tx),
    .o_busy(busy),
    .o_done(done),
    .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; model the FIFO (data valid only in the cycle after the read strobe).
  task automatic tick();
    @(negedge clk);
    if (pend) begin
      data = pend_word;
      pend = 1'b0;
    end else begin
      data = WIDTH'($urandom);
    end
    if (re === 1'b1 && fifo_q.size() > 0) begin
      pend_word = fifo_q.pop_front();
      pend      = 1'b1;
    end
    empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // Called in "cycle 0" (idle with a start condition presented); checks nframes complete frames then idle.
  task automatic tx_frames(input int nframes, input int drop_at);
    logic [WIDTH-1:0] w;
    logic             bits[NBITS];
    int               cyc;
    for (int f = 0; f < nframes; f++) begin
      w = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      bits[0] = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) bits[1+i] = w[i];
      if (P == 1) bits[1+WIDTH] = ^w;
      for (int s = 0; s < int'(STOPB); s++) bits[1+WIDTH+P+s] = 1'b1;
      tick();
      chk("pop_re", 16'(re), 16'd1);
      chk("pop_tx", 16'(tx), 16'd1);
      chk("pop_busy", 16'(busy), 16'd1);
      chk("pop_cnt", frame_cnt, exp_cnt);
      tick();
      chk("load_re", 16'(re), 16'd0);
      chk("load_tx", 16'(tx), 16'd1);
      cyc = 0;
      for (int b = 0; b < int'(NBITS); b++) begin
        for (int c = 0; c < int'(CPB); c++) begin
          tick();
          cyc++;
          if (cyc == drop_at) tx_en = 1'b0;
          chk($sformatf("tx_w%0h_b%0d", w, b), 16'(tx), 16'(bits[b]));
          chk("frame_re", 16'(re), 16'd0);
          chk("frame_busy", 16'(busy), 16'd1);
          chk("frame_done", 16'(done),
              16'((b == int'(NBITS) - 1) && (c == int'(CPB) - 1)));
        end
      end
      exp_cnt = exp_cnt + 16'd1;
    end
    tick();
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_tx", 16'(tx), 16'd1);
    chk("idle_re", 16'(re), 16'd0);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_cnt", frame_cnt, exp_cnt);
  endtask

  initial begin
    int n;
    int gap;
    rst_n = 1'b0;
    tx_en = 1'b1;
    empty = 1'b1;
    data  = '0;
    push(8'hA5);

    // Reset held for 3 cycles with a non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", 16'(tx), 16'd1);
      chk("rst_re", 16'(re), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_cnt", frame_cnt, 16'd0);
    end
    rst_n = 1'b1;
    tx_frames(1, -1);

    // Parity-sensitive words, then back-to-back pair.
    push(8'h07);
    tx_frames(1, -1);
    push(8'h00);
    push(8'hFF);
    tx_frames(2, -1);

    // Enable gating: nothing leaves the FIFO while disabled.
    tx_en = 1'b0;
    push(WIDTH'($urandom));
    push(WIDTH'($urandom));
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("gate_re", 16'(re), 16'd0);
      chk("gate_tx", 16'(tx), 16'd1);
    end
    tx_en = 1'b1;
    tx_frames(1, 10);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("drop_re", 16'(re), 16'd0);
    end
    chk("drop_left", 16'(fifo_q.size()), 16'd1);
    tx_en = 1'b1;
    tx_frames(1, -1);

    // Randomized bursts with random idle gaps.
    for (int k = 0; k < 6; k++) begin
      tx_en = 1'b0;
      n   = int'($urandom_range(1, 3));
      gap = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) push(WIDTH'($urandom));
      for (int i = 0; i < gap; i++) begin
        tick();
        chk("rgap_re", 16'(re), 16'd0);
      end
      tx_en = 1'b1;
      tx_frames(n, -1);
    end

    // Reset during data bit 3 abandons the frame; the popped word is lost.
    push(8'h00);
    push(8'h3C);
    for (int i = 0; i < 20; i++) tick();
    chk("mid_tx_b3", 16'(tx), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 16'(tx), 16'd1);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_re", 16'(re), 16'd0);
    chk("mid_rst_cnt", frame_cnt, 16'd0);
    exp_cnt = 16'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tx_frames(1, -1);
    chk("mid_after_cnt", frame_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
